// File: rtl/param_sync_fifo_pkg.sv
// Shared helpers for param_sync_fifo: width math,
// parameter legality checks and the flag bundle.
package param_sync_fifo_pkg;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        for (int i = 0; i < 32; i++) begin
            if (x > 0) begin
                r = r + 1;
                x = x >> 1;
            end
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit in_range(
        input int v,
        input int lo,
        input int hi
    );
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic bit params_ok(
        input int dw,
        input int depth,
        input int af,
        input int ae
    );
        return in_range(dw, 1, 256)
            && is_pow2(depth)
            && in_range(depth, 4, 1024)
            && in_range(af, 1, depth - 1)
            && in_range(ae, 1, depth - 1);
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: sync write, registered read.
// Contents are never reset; the pointers define validity.
module fifo_ram #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [1<<AW];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised synchronous FIFO with registered read,
// occupancy count, threshold flags and error pulses.
module param_sync_fifo
    import param_sync_fifo_pkg::*;
#(
    parameter int DW     = 8,
    parameter int DEPTH  = 16,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic [DW-1:0]          data_in,
    input  logic                   rd_en,
    output logic [DW-1:0]          data_out,
    output logic                   rd_valid,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [clog2(DEPTH):0]  count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C   = (AW+1)'(AF_LVL);
    localparam logic [AW:0] AE_C   = (AW+1)'(AE_LVL);

    generate
        if (!params_ok(DW, DEPTH, AF_LVL, AE_LVL)) begin : g_bad_params
            $error("param_sync_fifo: illegal parameter set");
        end
    endgenerate

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   occ;
    fifo_flags_t   flg;
    logic          wr_acc;
    logic          rd_acc;
    logic          rd_seen;
    logic [DW-1:0] ram_q;

    assign occ = wr_ptr - rd_ptr;

    always_comb begin
        flg              = '0;
        flg.full         = (occ == FULL_C);
        flg.empty        = (occ == '0);
        flg.almost_full  = (occ >= AF_C);
        flg.almost_empty = (occ <= AE_C);
    end

    // RST gates the RAM ports so nothing lands in the reset cycle
    assign wr_acc = wr_en & ~flg.full  & ~clr & ~RST;
    assign rd_acc = rd_en & ~flg.empty & ~clr & ~RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_valid  <= 1'b0;
            rd_seen   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_en & flg.full  & ~clr;
            underflow <= rd_en & flg.empty & ~clr;
            rd_valid  <= rd_acc;
            if (rd_acc) begin
                rd_seen <= 1'b1;
            end
            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_acc) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (rd_acc) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    fifo_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .CLK   (CLK),
        .we    (wr_acc),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (data_in),
        .re    (rd_acc),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (ram_q)
    );

    // the unreset RAM register reads as zero until a read since reset
    assign data_out     = rd_seen ? ram_q : '0;
    assign count        = occ;
    assign full         = flg.full;
    assign empty        = flg.empty;
    assign almost_full  = flg.almost_full;
    assign almost_empty = flg.almost_empty;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Randomised + directed bench for param_sync_fifo against
// a queue-based reference model.
module tb_param_sync_fifo;

    localparam int DW     = 8;
    localparam int DEPTH  = 16;
    localparam int AF_LVL = 14;
    localparam int AE_LVL = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          clr = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] data_out;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [4:0]    count;
    logic          overflow;
    logic          underflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_rv;
    logic          m_ovf;
    logic          m_udf;

    always #5 CLK = ~CLK;

    param_sync_fifo #(
        .DW     (DW),
        .DEPTH  (DEPTH),
        .AF_LVL (AF_LVL),
        .AE_LVL (AE_LVL)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .clr          (clr),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(
        input logic r,
        input logic c,
        input logic w,
        input logic [DW-1:0] d,
        input logic rd
    );
        bit was_full;
        bit was_empty;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (r) begin
            q.delete();
            m_dout = '0;
            m_rv   = 1'b0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else begin
            m_ovf = w && was_full && !c;
            m_udf = rd && was_empty && !c;
            if (c) begin
                q.delete();
                m_rv = 1'b0;
            end else begin
                m_rv = rd && !was_empty;
                if (m_rv) m_dout = q.pop_front();
                if (w && !was_full) q.push_back(d);
            end
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        check("count",    32'(count),        32'(n));
        check("empty",    32'(empty),        32'(n == 0));
        check("full",     32'(full),         32'(n == DEPTH));
        check("a_full",   32'(almost_full),  32'(n >= AF_LVL));
        check("a_empty",  32'(almost_empty), 32'(n <= AE_LVL));
        check("rd_valid", 32'(rd_valid),     32'(m_rv));
        check("data_out", 32'(data_out),     32'(m_dout));
        check("overflow", 32'(overflow),     32'(m_ovf));
        check("undrflow", 32'(underflow),    32'(m_udf));
    endtask

    task automatic step(
        input logic r,
        input logic c,
        input logic w,
        input logic [DW-1:0] d,
        input logic rd
    );
        RST     = r;
        clr     = c;
        wr_en   = w;
        data_in = d;
        rd_en   = rd;
        @(posedge CLK);
        model_edge(r, c, w, d, rd);
        #1;
        check_all();
    endtask

    task automatic fill_to(input int n);
        while (q.size() < n) begin
            step(1'b0, 1'b0, 1'b1, DW'($urandom), 1'b0);
        end
    endtask

    initial begin
        m_dout = '0;
        m_rv   = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        #2;
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);

        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b0, 1'b1, DW'(i), 1'b0);
        check("fill_full", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b0, '0, 1'b1);
            check("ord_data", 32'(data_out), 32'(i));
        end
        check("drain_empty", 32'(empty), 32'd1);

        fill_to(16);
        step(1'b0, 1'b0, 1'b1, 8'hEE, 1'b0);
        check("ovf_pulse", 32'(overflow), 32'd1);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        check("ovf_clear", 32'(overflow), 32'd0);
        step(1'b0, 1'b0, 1'b1, 8'h77, 1'b1);
        while (q.size() > 0)
            step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        check("udf_pulse", 32'(underflow), 32'd1);
        step(1'b0, 1'b0, 1'b1, 8'h3C, 1'b1);
        check("no_bypass", 32'(rd_valid), 32'd0);

        fill_to(8);
        for (int i = 0; i < 40; i++)
            step(1'b0, 1'b0, 1'b1, DW'($urandom), 1'b1);
        check("steady8", 32'(count), 32'd8);

        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        fill_to(5);
        step(1'b0, 1'b1, 1'b1, 8'h11, 1'b1);
        check("clr_cnt", 32'(count), 32'd0);

        fill_to(10);
        step(1'b1, 1'b0, 1'b1, 8'h22, 1'b1);
        check("rst_cnt", 32'(count), 32'd0);
        step(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        check("a5_back", 32'(data_out), 32'hA5);

        for (int i = 0; i < 3000; i++) begin
            logic r, c, w, rd;
            int   bias;
            bias = (i / 300) % 3;
            r  = ($urandom_range(0, 499) == 0);
            c  = ($urandom_range(0, 99) == 0);
            w  = ($urandom_range(0, 9) < (bias == 0 ? 8 : (bias == 1 ? 3 : 5)));
            rd = ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 8 : 5)));
            step(r, c, w, DW'($urandom), rd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter DW, default 8, data width in bits (1..256).
REQ-002 SHALL have parameter DEPTH, default 16, entry count, power of two, 4..1024.
REQ-003 SHALL have parameter AF_LVL, default DEPTH-2, almost_full threshold (1..DEPTH-1).
REQ-004 SHALL have parameter AE_LVL, default 2, almost_empty threshold (1..DEPTH-1).
REQ-005 SHALL derive AW = log2(DEPTH) internally; AW is not a user parameter.
REQ-006 CLK  input  1  rising-edge clock for all state.
REQ-007 RST  input  1  reset, synchronous, active-high.
REQ-008 clr  input  1  synchronous flush request.
REQ-009 wr_en  input  1  write request.
REQ-010 data_in  input  DW  write data.
REQ-011 rd_en  input  1  read request.
REQ-012 data_out  output  DW  registered read data.
REQ-013 rd_valid  output  1  data_out updated by a read accepted last cycle.
REQ-014 full, empty  output  1 each  occupancy == DEPTH / == 0.
REQ-015 almost_full, almost_empty  output  1 each  count >= AF_LVL / count <= AE_LVL.
REQ-016 count  output  AW+1  current occupancy, 0..DEPTH.
REQ-017 overflow, underflow  output  1 each  one-cycle error pulses.

Function
REQ-018 Write accepted iff wr_en & ~full & ~clr; data_in stored at wr_ptr, wr_ptr += 1.
REQ-019 Read accepted iff rd_en & ~empty & ~clr; rd_ptr += 1.
REQ-020 Pointers SHALL be AW+1 bits; low AW bits index storage, MSB is wrap bit; natural modulo-2^(AW+1) wrap.
REQ-021 count SHALL equal wr_ptr - rd_ptr (AW+1-bit subtraction), registered.
REQ-022 full/empty/almost_* SHALL be derived from registered pointers only, never from same-cycle wr_en/rd_en.
REQ-023 Read latency 1: accepted read in cycle N -> data_out valid and rd_valid=1 in N+1.
REQ-024 Without an accepted read, data_out SHALL hold its value and rd_valid SHALL be 0.
REQ-025 Simultaneous accepted read and write: count unchanged, both pointers advance.
REQ-026 At full with wr_en & rd_en: read accepted, write rejected, overflow=1 next cycle.
REQ-027 At empty with wr_en & rd_en: write accepted, read rejected, underflow=1 next cycle; no read-through bypass.
REQ-028 overflow = registered (wr_en & full & ~clr); underflow = registered (rd_en & empty & ~clr); each high exactly one cycle per rejected request.
REQ-029 clr SHALL zero both pointers next cycle, drive rd_valid=0, hold data_out, and override wr_en/rd_en in that cycle.
REQ-030 Storage contents SHALL not be reset or cleared; only pointers define valid data.

Reset
REQ-031 RST SHALL take priority over clr, wr_en, rd_en.
REQ-032 After RST: pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, rd_valid=0, data_out=0, overflow=0, underflow=0.
REQ-033 RST asserted mid-operation SHALL discard all contents in one cycle; no write or read accepted that cycle.

Structure
REQ-034 Shared package SHALL hold the clog2 helper and parameter-legality checks (power-of-two DEPTH, threshold ranges), failing elaboration on violation.
REQ-035 Storage SHALL be a sub-module fifo_ram: DEPTH x DW, one sync write port, one registered read port, no reset.
REQ-036 Pointer/flag logic SHALL reside in param_sync_fifo; no latches, single clock domain.

Verification (DW=8, DEPTH=16, AF_LVL=14, AE_LVL=2)
REQ-037 RST then write 0x00..0x0F -> full=1, count=16, almost_full=1 from count 14; 16 reads return 0x00..0x0F in order, each rd_valid one cycle after rd_en; empty=1 after last.
REQ-038 Full FIFO, wr_en=1 rd_en=0 one cycle -> overflow pulses once, count stays 16, contents unchanged.
REQ-039 Empty FIFO, rd_en=1 -> underflow pulses once, rd_valid=0, data_out holds previous value.
REQ-040 Hold count=8, wr_en=rd_en=1 for 40 cycles (pointers wrap twice) -> count stays 8, output order matches input order.
REQ-041 count=5, assert clr with wr_en=rd_en=1 -> next cycle count=0, empty=1, no rd_valid, no overflow/underflow.
REQ-042 RST asserted at count=10 during write -> next cycle all outputs at REQ-032 values; subsequent write/read of 0xA5 returns 0xA5.
